// File: rtl/rsa_pkg.sv
// Shared widths, FSM state type and the modular-multiply step for the RSA decrypt core.
// The optional modulus guard is enabled with RSA_MODULUS_CHECK_EN (see rsa_decrypt_core).
package rsa_pkg;

    localparam int WORD_W        = 32;
    localparam int ACC_W         = 34;
    localparam int MODMUL_CYCLES = 32;
    localparam int CNT_W         = $clog2(MODMUL_CYCLES);
    localparam int IDX_W         = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        SQUARE,
        MULT,
        DONE
    } state_e;

    // One interleaved shift-add step; with acc < n and a < n the sum stays below 3n,
    // so two conditional subtractions are enough to bring it back under n.
    function automatic logic [ACC_W-1:0] modmulStep(
        input logic [ACC_W-1:0]  acc,
        input logic              bitSel,
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] n
    );
        logic [ACC_W-1:0] t;
        logic [ACC_W-1:0] nExt;
        nExt = {{(ACC_W-WORD_W){1'b0}}, n};
        t    = (acc << 1) + (bitSel ? {{(ACC_W-WORD_W){1'b0}}, a} : {ACC_W{1'b0}});
        if (t >= nExt) t = t - nExt;
        if (t >= nExt) t = t - nExt;
        return t;
    endfunction

endpackage

// File: rtl/rsa_decrypt_core_if.sv
// Job and result handshake bundle for rsa_decrypt_core.
interface rsa_decrypt_core_if;
    import rsa_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] n;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] c;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] m;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, n, d, c, out_ready,
        input  in_ready, out_valid, m, busy, err
    );

    modport slave (
        input  in_valid, n, d, c, out_ready,
        output in_ready, out_valid, m, busy, err
    );

endinterface

// File: rtl/rsa_modmul.sv
// Serial modular multiplier: res = a*b mod n, one b bit per cycle MSB first, 32 cycles per job.
// The start cycle already consumes b[31]; done pulses for one cycle once res is final.
module rsa_modmul
    import rsa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [WORD_W-1:0] n_i,
    output logic              done_o,
    output logic [WORD_W-1:0] res_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MODMUL_CYCLES - 1);

    logic [ACC_W-1:0]  acc_q,  acc_d;
    logic [WORD_W-1:0] a_q,    a_d;
    logic [WORD_W-1:0] b_q,    b_d;
    logic [WORD_W-1:0] n_q,    n_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              run_q,  run_d;

    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        n_d   = n_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            acc_d = modmulStep('0, b_i[WORD_W-1], a_i, n_i);
            a_d   = a_i;
            b_d   = {b_i[WORD_W-2:0], 1'b0};
            n_d   = n_i;
            cnt_d = LAST_CNT;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                acc_d = modmulStep(acc_q, b_q[WORD_W-1], a_q, n_q);
                b_d   = {b_q[WORD_W-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            n_q   <= n_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign res_o  = acc_q[WORD_W-1:0];

endmodule

// File: rtl/rsa_decrypt_core.sv
// RSA decryption m = c^d mod n by MSB-first square-and-multiply over a shared serial modmul.
// Define RSA_MODULUS_CHECK_EN to reject n<2 immediately with err=1 and m=0.
module rsa_decrypt_core
    import rsa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rsa_decrypt_core_if.slave bus
);

    state_e            state_q;
    logic [WORD_W-1:0] n_q;
    logic [WORD_W-1:0] d_q;
    logic [WORD_W-1:0] c_q;
    logic [WORD_W-1:0] cr_q;
    logic [WORD_W-1:0] m_q;
    logic [IDX_W-1:0]  idx_q;
    logic              launch_q;
    logic              inReady_q;
    logic              outValid_q;
    logic              busy_q;
    logic              err_q;

    logic              mmStart;
    logic              mmDone;
    logic [WORD_W-1:0] mmA;
    logic [WORD_W-1:0] mmB;
    logic [WORD_W-1:0] mmRes;
    logic              guardHit;

`ifdef RSA_MODULUS_CHECK_EN
    assign guardHit = launch_q && (n_q < WORD_W'(2));
`else
    assign guardHit = 1'b0;
`endif

    // Each new product is launched on the same edge the previous one completes, so every
    // modmul costs exactly 32 edges; the result feeds the next operands combinationally.
    always_comb begin
        mmStart = 1'b0;
        mmA     = '0;
        mmB     = '0;
        case (state_q)
            REDUCE: begin
                if (launch_q && !guardHit) begin
                    mmStart = 1'b1;
                    mmA     = WORD_W'(1);
                    mmB     = c_q;
                end else if (mmDone) begin
                    mmStart = 1'b1;
                    mmA     = WORD_W'(1);
                    mmB     = WORD_W'(1);
                end
            end
            SQUARE: begin
                if (mmDone) begin
                    if (d_q[idx_q]) begin
                        mmStart = 1'b1;
                        mmA     = mmRes;
                        mmB     = cr_q;
                    end else if (idx_q != '0) begin
                        mmStart = 1'b1;
                        mmA     = mmRes;
                        mmB     = mmRes;
                    end
                end
            end
            MULT: begin
                if (mmDone && (idx_q != '0)) begin
                    mmStart = 1'b1;
                    mmA     = mmRes;
                    mmB     = mmRes;
                end
            end
            default: ;
        endcase
    end

    rsa_modmul u_modmul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mmStart),
        .a_i     (mmA),
        .b_i     (mmB),
        .n_i     (n_q),
        .done_o  (mmDone),
        .res_o   (mmRes)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            d_q        <= '0;
            c_q        <= '0;
            cr_q       <= '0;
            m_q        <= '0;
            idx_q      <= '0;
            launch_q   <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && inReady_q) begin
                        n_q       <= bus.n;
                        d_q       <= bus.d;
                        c_q       <= bus.c;
                        idx_q     <= '1;
                        launch_q  <= 1'b1;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= REDUCE;
                    end
                end
                REDUCE: begin
                    launch_q <= 1'b0;
                    if (guardHit) begin
                        m_q        <= '0;
                        err_q      <= 1'b1;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (mmDone) begin
                        cr_q    <= mmRes;
                        state_q <= SQUARE;
                    end
                end
                SQUARE: begin
                    if (mmDone) begin
                        if (d_q[idx_q]) begin
                            state_q <= MULT;
                        end else if (idx_q == '0) begin
                            m_q        <= mmRes;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (mmDone) begin
                        if (idx_q == '0) begin
                            m_q        <= mmRes;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            idx_q   <= idx_q - 1'b1;
                            state_q <= SQUARE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.m         = m_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Scoreboard bench for rsa_decrypt_core: a tracker pushes model results at each accept,
// a monitor pops and compares them (value, err, latency) whenever a result is handed off.
module tb_rsa_decrypt_core;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rsa_decrypt_core_if bus();

    rsa_decrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] m;
        logic        err;
        int          acceptCycle;
        int          latency;
    } exp_t;

    exp_t sbQ[$];
    int   cycle     = 0;
    int   numChecks = 0;
    int   numFails  = 0;
    logic prevOv    = 1'b0;

    // Plain LSB-first square-and-multiply on 64-bit integers.
    function automatic logic [31:0] refModExp(input logic [31:0] n, input logic [31:0] d,
                                              input logic [31:0] c);
        logic [63:0] nn, base, res;
        nn   = {32'd0, n};
        res  = 64'd1 % nn;
        base = {32'd0, c} % nn;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) res = (res * base) % nn;
            base = (base * base) % nn;
        end
        return res[31:0];
    endfunction

    function automatic int expLatency(input logic [31:0] d);
        return 32 * (33 + $countones(d)) + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), wanted %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycle);
        end
    endtask

    task automatic reportFail(input string name);
        numChecks++;
        numFails++;
        $display("[TB] FAIL %s at cycle %0d", name, cycle);
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Accept tracker and result monitor, both sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prevOv = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                e.acceptCycle = cycle + 1;
`ifdef RSA_MODULUS_CHECK_EN
                if (bus.n < 32'd2) begin
                    e.m       = 32'd0;
                    e.err     = 1'b1;
                    e.latency = 1;
                end else begin
                    e.m       = refModExp(bus.n, bus.d, bus.c);
                    e.err     = 1'b0;
                    e.latency = expLatency(bus.d);
                end
`else
                e.m       = refModExp(bus.n, bus.d, bus.c);
                e.err     = 1'b0;
                e.latency = expLatency(bus.d);
`endif
                sbQ.push_back(e);
            end
            if (bus.out_valid && !prevOv) begin
                if (sbQ.size() == 0) reportFail("unexpected out_valid");
                else checkOutput("latency", 32'(cycle - sbQ[0].acceptCycle), 32'(sbQ[0].latency));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbQ.size() == 0) begin
                    reportFail("result with empty scoreboard");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("m", bus.m, e.m);
                    checkOutput("err", 32'(bus.err), 32'(e.err));
                end
            end
            prevOv = bus.out_valid;
        end
    end

    task automatic applyStimulus(input logic [31:0] nIn, input logic [31:0] dIn,
                                 input logic [31:0] cIn);
        int waited = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && waited < 2500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) reportFail("in_ready timeout");
        bus.in_valid = 1'b1;
        bus.n = nIn;
        bus.d = dIn;
        bus.c = cIn;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.n = $urandom;
        bus.d = $urandom;
        bus.c = $urandom;
    endtask

    task automatic waitJobDone(input int bound);
        int waited = 0;
        while (!(sbQ.size() == 0 && bus.in_ready) && waited < bound) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!(sbQ.size() == 0 && bus.in_ready)) begin
            reportFail("job completion timeout");
            sbQ.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rn, rd, rc, expM;
        logic        sawOv;
        int          waited;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.n = '0;
        bus.d = '0;
        bus.c = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset err", 32'(bus.err), 32'd0);
        checkOutput("reset m", bus.m, 32'd0);
        rst = 1'b0;

        $display("[TB] standard job and operand edges");
        applyStimulus(32'd3233, 32'd2753, 32'd2790);
        waitJobDone(2500);
        applyStimulus(32'd3233, 32'd0, 32'd77);
        waitJobDone(2500);
        applyStimulus(32'd3233, 32'd2753, 32'd6023);
        waitJobDone(2500);
        applyStimulus(32'd3233, 32'd5, 32'd0);
        waitJobDone(2500);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        expM = refModExp(32'd3233, 32'd17, 32'd65);
        applyStimulus(32'd3233, 32'd17, 32'd65);
        waited = 0;
        while (!bus.out_valid && waited < 2500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.out_valid) reportFail("out_valid timeout under backpressure");
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            checkOutput("held m", bus.m, expM);
            checkOutput("held out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("held busy", 32'(bus.busy), 32'd1);
            checkOutput("held in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("release out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release busy", 32'(bus.busy), 32'd0);

        $display("[TB] reset mid-job");
        applyStimulus(32'd3233, 32'd2753, 32'd2790);
        repeat (499) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        sbQ.delete();
        sawOv = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            sawOv = sawOv | bus.out_valid;
        end
        checkOutput("no result after abort", 32'(sawOv), 32'd0);
        applyStimulus(32'd3233, 32'd2753, 32'd2790);
        waitJobDone(2500);

        $display("[TB] input while busy");
        applyStimulus(32'd3233, 32'd2753, 32'd2790);
        repeat (100) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.n = 32'd1000;
        bus.d = 32'd3;
        bus.c = 32'd7;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("busy in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        waitJobDone(2500);

        $display("[TB] maximum exponent");
        rn = $urandom | 32'h8000_0001;
        applyStimulus(rn, 32'hFFFF_FFFF, $urandom);
        waitJobDone(2500);

`ifdef RSA_MODULUS_CHECK_EN
        $display("[TB] modulus guard");
        applyStimulus(32'd1, 32'd5, 32'd9);
        waitJobDone(100);
`endif

        $display("[TB] random jobs");
        for (int i = 0; i < 6; i++) begin
            rn = $urandom;
            if (rn < 32'd2) rn = rn + 32'd2;
            rd = $urandom;
            rc = $urandom;
            applyStimulus(rn, rd, rc);
            waitJobDone(2500);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
